map_cfg_loader: RTL and testbench

- Writer side of the mapper configuration interface: receives a framed configuration stream from the MCU link, checks it, and atomically publishes the system configuration word.
- The mapper hub reads the published word. It uses `map_idx` (byte 0) to select the active mapper output.
- Holds the mapper core in reset around each commit, so no mapper ever sees a half-updated configuration.

---
 rtl/map_cfg_loader.sv | 144 ++++++++++++++
 tb/tb_map_cfg_loader.sv | 266 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/map_cfg_loader.sv
// Mapper configuration loader: parses SYNC + payload + XOR checksum frames and
// atomically publishes the configuration word while holding the mapper core in reset.
module map_cfg_loader #(
  parameter int unsigned CFG_BYTES = 8,
  parameter logic [7:0]  SYNC_BYTE = 8'h5A,
  parameter int unsigned RST_CYC   = 16,
  parameter int unsigned TIMEOUT   = 1024
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [7:0]             in_data,
  input  logic                   in_valid,
  output logic                   in_ready,
  output logic [CFG_BYTES*8-1:0] sys_cfg,
  output logic [7:0]             map_idx,
  output logic                   map_rst,
  output logic                   cfg_upd,
  output logic                   cfg_err,
  output logic                   busy
);

  localparam int unsigned WW = CFG_BYTES * 8;
  localparam int unsigned CW = (CFG_BYTES > 1) ? $clog2(CFG_BYTES) : 1;
  localparam int unsigned TW = $clog2(TIMEOUT + 1);

  typedef enum logic [1:0] {StIdle, StPayload, StCheck, StHold} state_e;

  state_e          state_q;
  logic [CW-1:0]   cnt_q;
  logic [TW-1:0]   tmo_q;
  logic [7:0]      hold_q;
  logic [7:0]      acc_q;
  logic [WW-1:0]   shadow_q;
  logic [WW-1:0]   cfg_q;
  logic            in_ready_q;
  logic            map_rst_q;
  logic            upd_q;
  logic            err_q;

  logic accept;
  logic tmo_hit;

  assign accept  = in_valid && in_ready_q;
  // Abort on the cycle that would bring the idle count up to TIMEOUT.
  assign tmo_hit = !accept && (tmo_q == TW'(TIMEOUT - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= StIdle;
      cnt_q      <= '0;
      tmo_q      <= '0;
      hold_q     <= '0;
      acc_q      <= '0;
      shadow_q   <= '0;
      cfg_q      <= '0;
      in_ready_q <= 1'b0;
      map_rst_q  <= 1'b1;
      upd_q      <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      upd_q <= 1'b0;
      unique case (state_q)
        StIdle: begin
          in_ready_q <= 1'b1;
          map_rst_q  <= 1'b0;
          if (accept && (in_data == SYNC_BYTE)) begin
            cnt_q   <= '0;
            acc_q   <= '0;
            tmo_q   <= '0;
            state_q <= StPayload;
          end
        end

        StPayload: begin
          if (accept) begin
            for (int k = 0; k < CFG_BYTES; k++) begin
              if (cnt_q == CW'(k)) shadow_q[8*k +: 8] <= in_data;
            end
            acc_q <= acc_q ^ in_data;
            tmo_q <= '0;
            if (cnt_q == CW'(CFG_BYTES - 1)) begin
              state_q <= StCheck;
            end else begin
              cnt_q <= cnt_q + 1'b1;
            end
          end else if (tmo_hit) begin
            err_q    <= 1'b1;
            shadow_q <= '0;
            state_q  <= StIdle;
          end else begin
            tmo_q <= tmo_q + 1'b1;
          end
        end

        StCheck: begin
          if (accept) begin
            tmo_q <= '0;
            if (in_data == acc_q) begin
              // Whole-word publish and mapper reset happen on the same edge.
              cfg_q      <= shadow_q;
              upd_q      <= 1'b1;
              map_rst_q  <= 1'b1;
              err_q      <= 1'b0;
              hold_q     <= 8'(RST_CYC);
              in_ready_q <= 1'b0;
              state_q    <= StHold;
            end else begin
              err_q   <= 1'b1;
              state_q <= StIdle;
            end
          end else if (tmo_hit) begin
            err_q    <= 1'b1;
            shadow_q <= '0;
            state_q  <= StIdle;
          end else begin
            tmo_q <= tmo_q + 1'b1;
          end
        end

        StHold: begin
          if (hold_q <= 8'd1) begin
            hold_q     <= '0;
            map_rst_q  <= 1'b0;
            in_ready_q <= 1'b1;
            state_q    <= StIdle;
          end else begin
            hold_q <= hold_q - 1'b1;
          end
        end

        default: state_q <= StIdle;
      endcase
    end
  end

  assign in_ready = in_ready_q;
  assign sys_cfg  = cfg_q;
  assign map_idx  = cfg_q[7:0];
  assign map_rst  = map_rst_q;
  assign cfg_upd  = upd_q;
  assign cfg_err  = err_q;
  assign busy     = (state_q != StIdle);

endmodule

// File: tb/tb_map_cfg_loader.sv
// Directed bench for map_cfg_loader: commits, checksum errors, garbage, timeout,
// mid-frame reset and back-to-back frames across the mapper hold window.
module tb_map_cfg_loader;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [7:0]  in_data;
  logic        in_valid;
  logic        in_ready;
  logic [63:0] sys_cfg;
  logic [7:0]  map_idx;
  logic        map_rst;
  logic        cfg_upd;
  logic        cfg_err;
  logic        busy;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  int upd_cnt = 0;
  logic [63:0] upd_log[$];

  map_cfg_loader #(
    .CFG_BYTES(8),
    .SYNC_BYTE(8'h5A),
    .RST_CYC  (16),
    .TIMEOUT  (1024)
  ) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .in_data (in_data),
    .in_valid(in_valid),
    .in_ready(in_ready),
    .sys_cfg (sys_cfg),
    .map_idx (map_idx),
    .map_rst (map_rst),
    .cfg_upd (cfg_upd),
    .cfg_err (cfg_err),
    .busy    (busy)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (cfg_upd) begin
      upd_cnt <= upd_cnt + 1;
      upd_log.push_back(sys_cfg);
    end
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [7:0] xsum(input logic [63:0] p);
    logic [7:0] x = 8'h00;
    for (int k = 0; k < 8; k++) x ^= p[8*k +: 8];
    return x;
  endfunction

  // Leaves in_valid high after the byte is taken; callers drop it when idle.
  task automatic send_byte(input logic [7:0] b);
    int n = 0;
    in_data  = b;
    in_valid = 1'b1;
    while (!in_ready && n < 100) begin
      @(posedge clk); #1;
      n++;
    end
    if (!in_ready) begin
      check("accept_timeout", 64'(n), 64'd0);
      return;
    end
    @(posedge clk); #1;
  endtask

  task automatic send_frame(input logic [63:0] p, input logic [7:0] ck);
    send_byte(8'h5A);
    for (int k = 0; k < 8; k++) send_byte(p[8*k +: 8]);
    send_byte(ck);
  endtask

  task automatic wait_hold(output int n, output logic rdy_seen);
    n = 0;
    rdy_seen = 1'b0;
    while (map_rst && n < 100) begin
      rdy_seen |= in_ready;
      @(posedge clk); #1;
      n++;
    end
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk); #1;
    end
  endtask

  initial begin
    int          n;
    int          u0;
    int          c_a;
    int          c_s;
    logic        rdy;
    logic [63:0] pa;
    logic [63:0] pb;

    rst_n    = 1'b0;
    in_valid = 1'b0;
    in_data  = 8'h00;

    // Reset values
    tick(3);
    check("rst_sys_cfg", sys_cfg, 64'h0);
    check("rst_map_idx", 64'(map_idx), 64'h0);
    check("rst_map_rst", 64'(map_rst), 64'd1);
    check("rst_in_ready", 64'(in_ready), 64'd0);
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_cfg_err", 64'(cfg_err), 64'd0);
    rst_n = 1'b1;
    tick(1);
    check("rel_map_rst", 64'(map_rst), 64'd0);
    check("rel_in_ready", 64'(in_ready), 64'd1);

    // Basic commit
    send_frame(64'h07, 8'h07);
    in_valid = 1'b0;
    check("s1_cfg_upd", 64'(cfg_upd), 64'd1);
    check("s1_sys_cfg", sys_cfg, 64'h07);
    check("s1_map_idx", 64'(map_idx), 64'h07);
    check("s1_map_rst", 64'(map_rst), 64'd1);
    check("s1_in_ready", 64'(in_ready), 64'd0);
    check("s1_busy", 64'(busy), 64'd1);
    wait_hold(n, rdy);
    check("s1_hold_len", 64'(n), 64'd16);
    check("s1_rdy_in_hold", 64'(rdy), 64'd0);
    check("s1_busy_after", 64'(busy), 64'd0);
    check("s1_upd_cnt", 64'(upd_cnt), 64'd1);

    // Bad checksum
    send_frame(64'h07, 8'h06);
    in_valid = 1'b0;
    check("s2_cfg_err", 64'(cfg_err), 64'd1);
    check("s2_sys_cfg", sys_cfg, 64'h07);
    check("s2_map_rst", 64'(map_rst), 64'd0);
    check("s2_busy", 64'(busy), 64'd0);
    check("s2_upd", 64'(cfg_upd), 64'd0);
    tick(3);
    check("s2_upd_cnt", 64'(upd_cnt), 64'd1);
    check("s2_map_rst_later", 64'(map_rst), 64'd0);

    // Recovery frame selecting 0xE4
    pa = 64'hA1B2_C3D4_E5F6_07E4;
    send_frame(pa, xsum(pa));
    in_valid = 1'b0;
    check("s3_cfg_err", 64'(cfg_err), 64'd0);
    check("s3_map_idx", 64'(map_idx), 64'hE4);
    check("s3_sys_cfg", sys_cfg, pa);
    wait_hold(n, rdy);
    check("s3_hold_len", 64'(n), 64'd16);

    // Garbage before sync
    send_byte(8'h00);
    send_byte(8'hFF);
    send_byte(8'h13);
    in_valid = 1'b0;
    check("s4_busy_garbage", 64'(busy), 64'd0);
    check("s4_err_garbage", 64'(cfg_err), 64'd0);
    u0 = upd_cnt;
    send_frame(64'h07, 8'h07);
    in_valid = 1'b0;
    check("s4_sys_cfg", sys_cfg, 64'h07);
    check("s4_map_idx", 64'(map_idx), 64'h07);
    wait_hold(n, rdy);
    check("s4_hold_len", 64'(n), 64'd16);
    check("s4_upd_cnt", 64'(upd_cnt - u0), 64'd1);

    // Timeout after 3 payload bytes
    send_byte(8'h5A);
    send_byte(8'h11);
    send_byte(8'h22);
    send_byte(8'h33);
    in_valid = 1'b0;
    tick(1023);
    check("s5_busy_1023", 64'(busy), 64'd1);
    check("s5_err_1023", 64'(cfg_err), 64'd0);
    tick(1);
    check("s5_err_1024", 64'(cfg_err), 64'd1);
    check("s5_busy_1024", 64'(busy), 64'd0);
    check("s5_sys_cfg_kept", sys_cfg, 64'h07);
    pb = 64'h0102_0304_0506_0708;
    send_frame(pb, xsum(pb));
    in_valid = 1'b0;
    check("s5_recover_cfg", sys_cfg, pb);
    check("s5_recover_err", 64'(cfg_err), 64'd0);
    wait_hold(n, rdy);

    // Reset in the middle of a frame
    send_byte(8'h5A);
    send_byte(8'h11);
    send_byte(8'h22);
    send_byte(8'h33);
    send_byte(8'h44);
    in_valid = 1'b0;
    rst_n = 1'b0;
    #1;
    check("s6_sys_cfg", sys_cfg, 64'h0);
    check("s6_map_rst", 64'(map_rst), 64'd1);
    check("s6_in_ready", 64'(in_ready), 64'd0);
    check("s6_busy", 64'(busy), 64'd0);
    tick(2);
    rst_n = 1'b1;
    tick(1);
    check("s6_rel_map_rst", 64'(map_rst), 64'd0);
    check("s6_rel_in_ready", 64'(in_ready), 64'd1);
    send_byte(8'h55);
    send_byte(8'h66);
    send_byte(8'h77);
    send_byte(8'h88);
    send_byte(8'h99);
    in_valid = 1'b0;
    tick(2);
    check("s6_tail_cfg", sys_cfg, 64'h0);
    check("s6_tail_busy", 64'(busy), 64'd0);
    pa = 64'h0000_0000_0000_0042;
    send_frame(pa, xsum(pa));
    in_valid = 1'b0;
    check("s6_new_cfg", sys_cfg, pa);
    wait_hold(n, rdy);

    // Back-to-back frames, in_valid held high through the hold window
    u0 = upd_cnt;
    pa = 64'h0000_0000_0000_0003;
    pb = 64'h5A00_0000_0000_5A09;
    send_frame(pa, xsum(pa));
    c_a = cyc;
    check("s7_in_ready_hold", 64'(in_ready), 64'd0);
    send_byte(8'h5A);
    c_s = cyc;
    check("s7_sync_delay", 64'(c_s - c_a), 64'd17);
    check("s7_map_rst_low", 64'(map_rst), 64'd0);
    check("s7_busy_sync", 64'(busy), 64'd1);
    for (int k = 0; k < 8; k++) send_byte(pb[8*k +: 8]);
    send_byte(xsum(pb));
    in_valid = 1'b0;
    check("s7_cfg_b", sys_cfg, pb);
    wait_hold(n, rdy);
    check("s7_hold_len", 64'(n), 64'd16);
    check("s7_upd_cnt", 64'(upd_cnt - u0), 64'd2);
    if (upd_log.size() >= 2) begin
      check("s7_order_a", upd_log[upd_log.size()-2], pa);
      check("s7_order_b", upd_log[upd_log.size()-1], pb);
    end else begin
      check("s7_log_size", 64'(upd_log.size()), 64'd2);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
